level_crossing_ctrl: RTL and testbench

- Parametrised successor to the single-track rail gate controller.
- Sequences one road signal, N_TRACKS per-track signals and a physical barrier with sensor feedback.
- Yellow dwell is a configurable counted delay, not a fixed one.
- Barrier motion is supervised by a timeout that drops the block into a sticky safe FAULT state.

---
 rtl/level_crossing_ctrl.sv | 138 +++++++++++++
 tb/tb_level_crossing_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/level_crossing_ctrl.sv
// Level crossing sequencer: road light, per-track lights and a supervised barrier with a sticky timeout fault.
// Latency: road/gate/fault registered alongside the state; track decodes train combinationally in TRACK_GREEN; no backpressure.
module level_crossing_ctrl #(
    parameter int N_TRACKS      = 2,
    parameter int YELLOW_CYCLES = 2,
    parameter int GATE_TIMEOUT  = 16
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic [N_TRACKS-1:0]   train,
    input  logic                  gate_closed,
    input  logic                  fault_clr,
    output logic [1:0]            road,
    output logic [2*N_TRACKS-1:0] track,
    output logic                  gate_down,
    output logic                  fault,
    output logic [2:0]            state_o
);

    localparam int MAXC = (YELLOW_CYCLES > GATE_TIMEOUT) ? YELLOW_CYCLES : GATE_TIMEOUT;
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [CW-1:0] YC_LAST  = CW'(YELLOW_CYCLES - 1);
    localparam logic [CW-1:0] GT_LAST  = CW'(GATE_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    localparam logic [1:0] SIG_RED    = 2'd0;
    localparam logic [1:0] SIG_YELLOW = 2'd1;
    localparam logic [1:0] SIG_GREEN  = 2'd2;

    typedef enum logic [2:0] {
        ST_ROAD_GREEN    = 3'd0,
        ST_ROAD_YELLOW   = 3'd1,
        ST_GATE_LOWERING = 3'd2,
        ST_TRACK_GREEN   = 3'd3,
        ST_TRACK_YELLOW  = 3'd4,
        ST_GATE_RAISING  = 3'd5,
        ST_FAULT         = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_road;
    logic            r_gate_down;
    logic            r_fault;
    logic            w_any_train;

    assign w_any_train = |train;

    function automatic logic [1:0] road_of(input state_t s);
        case (s)
            ST_ROAD_GREEN:  road_of = SIG_GREEN;
            ST_ROAD_YELLOW: road_of = SIG_YELLOW;
            default:        road_of = SIG_RED;
        endcase
    endfunction

    function automatic logic gate_of(input state_t s);
        case (s)
            ST_GATE_LOWERING, ST_TRACK_GREEN,
            ST_TRACK_YELLOW, ST_FAULT: gate_of = 1'b1;
            default:                   gate_of = 1'b0;
        endcase
    endfunction

    // Priority order inside each state matters: gate_closed beats the lowering
    // timeout, and a returning train beats every other exit from yellow/raising.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ROAD_GREEN: begin
                if (w_any_train) w_next = ST_ROAD_YELLOW;
            end
            ST_ROAD_YELLOW: begin
                if (r_cnt == YC_LAST) w_next = ST_GATE_LOWERING;
            end
            ST_GATE_LOWERING: begin
                if (gate_closed)            w_next = ST_TRACK_GREEN;
                else if (r_cnt == GT_LAST)  w_next = ST_FAULT;
            end
            ST_TRACK_GREEN: begin
                if (!w_any_train) w_next = ST_TRACK_YELLOW;
            end
            ST_TRACK_YELLOW: begin
                if (w_any_train)            w_next = ST_TRACK_GREEN;
                else if (r_cnt == YC_LAST)  w_next = ST_GATE_RAISING;
            end
            ST_GATE_RAISING: begin
                if (w_any_train)            w_next = ST_GATE_LOWERING;
                else if (!gate_closed)      w_next = ST_ROAD_GREEN;
                else if (r_cnt == GT_LAST)  w_next = ST_FAULT;
            end
            ST_FAULT: begin
                if (fault_clr && !w_any_train) w_next = ST_GATE_RAISING;
            end
            default: w_next = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= ST_ROAD_GREEN;
            r_cnt       <= '0;
            r_road      <= SIG_GREEN;
            r_gate_down <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_road      <= road_of(w_next);
            r_gate_down <= gate_of(w_next);
            r_fault     <= (w_next == ST_FAULT);
            // Saturate so a long stay in an idle state never aliases a timeout value.
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + CW'(1);
        end
    end

    always_comb begin
        track = '0;
        for (int i = 0; i < N_TRACKS; i++) begin
            if (r_state == ST_TRACK_GREEN)
                track[2*i +: 2] = train[i] ? SIG_GREEN : SIG_RED;
            else if (r_state == ST_TRACK_YELLOW)
                track[2*i +: 2] = SIG_YELLOW;
            else
                track[2*i +: 2] = SIG_RED;
        end
    end

    assign road      = r_road;
    assign gate_down = r_gate_down;
    assign fault     = r_fault;
    assign state_o   = r_state;

endmodule

// File: tb/tb_level_crossing_ctrl.sv
// Directed bench for level_crossing_ctrl (N_TRACKS=2, YELLOW_CYCLES=2, GATE_TIMEOUT=16).
// Vectors: {train[1:0], gate_closed, fault_clr, expected state[2:0], expected track[3:0]}.
module tb_level_crossing_ctrl;

    localparam logic [2:0] S_RG = 3'd0, S_RY = 3'd1, S_GL = 3'd2, S_TG = 3'd3,
                           S_TY = 3'd4, S_GR = 3'd5, S_F  = 3'd6;
    localparam logic [3:0] T_RR = 4'b0000, T_G0 = 4'b0010, T_G1 = 4'b1000,
                           T_GG = 4'b1010, T_YY = 4'b0101;

    localparam logic [1:0] ROAD_EXP [0:7] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    localparam logic       GD_EXP   [0:7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic [1:0] train = 2'b00;
    logic       gate_closed = 1'b0;
    logic       fault_clr = 1'b0;
    logic [1:0] road;
    logic [3:0] track;
    logic       gate_down;
    logic       fault;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;
    logic last_gc;

    level_crossing_ctrl #(.N_TRACKS(2), .YELLOW_CYCLES(2), .GATE_TIMEOUT(16)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .train      (train),
        .gate_closed(gate_closed),
        .fault_clr  (fault_clr),
        .road       (road),
        .track      (track),
        .gate_down  (gate_down),
        .fault      (fault),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) last_gc <= 1'b0;
        else        last_gc <= gate_closed;
    end

    always @(negedge clk) begin
        if (clr_n) begin
            checks++;
            if (track != 4'b0000 && (road !== 2'd0 || gate_down !== 1'b1)) begin
                errors++;
                $display("FAIL inv_track_safe t=%0t: road=%0d gate_down=%b track=%b, required road=0 gate_down=1", $time, road, gate_down, track);
            end
            checks++;
            if (road === 2'd2 && last_gc !== 1'b0) begin
                errors++;
                $display("FAIL inv_road_green t=%0t: road=GREEN with last gate_closed=%b, required 0", $time, last_gc);
            end
        end
    end

    task automatic test_reset();
        #1 clr_n = 1'b0;
        #2;
        checks++;
        if (state_o !== S_RG) begin errors++; $display("FAIL reset_state: got %0d, required 0", state_o); end
        checks++;
        if (road !== 2'd2) begin errors++; $display("FAIL reset_road: got %0d, required 2", road); end
        checks++;
        if (track !== T_RR) begin errors++; $display("FAIL reset_track: got %b, required 0000", track); end
        checks++;
        if (gate_down !== 1'b0 || fault !== 1'b0) begin
            errors++; $display("FAIL reset_gate_fault: got gd=%b fault=%b, required 0 0", gate_down, fault);
        end
        @(negedge clk);
        #2 clr_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (state_o !== S_RG) begin errors++; $display("FAIL reset_idle: got %0d, required 0", state_o); end
    endtask

    task automatic test_nominal();
        logic [10:0] q[$];
        q = '{ {2'b01,1'b0,1'b0,S_RY,T_RR}, {2'b01,1'b0,1'b0,S_RY,T_RR},
               {2'b01,1'b0,1'b0,S_GL,T_RR}, {2'b01,1'b0,1'b0,S_GL,T_RR},
               {2'b01,1'b0,1'b0,S_GL,T_RR}, {2'b01,1'b1,1'b0,S_TG,T_G0},
               {2'b01,1'b1,1'b0,S_TG,T_G0}, {2'b01,1'b1,1'b0,S_TG,T_G0},
               {2'b00,1'b1,1'b0,S_TY,T_YY}, {2'b00,1'b1,1'b0,S_TY,T_YY},
               {2'b00,1'b1,1'b0,S_GR,T_RR}, {2'b00,1'b1,1'b0,S_GR,T_RR},
               {2'b00,1'b1,1'b0,S_GR,T_RR}, {2'b00,1'b0,1'b0,S_RG,T_RR} };
        foreach (q[i]) begin
            {train, gate_closed, fault_clr} = q[i][10:7];
            @(posedge clk); #1;
            checks++;
            if (state_o !== q[i][6:4] || track !== q[i][3:0] || road !== ROAD_EXP[q[i][6:4]] ||
                gate_down !== GD_EXP[q[i][6:4]] || fault !== (q[i][6:4] == S_F)) begin
                errors++;
                $display("FAIL nominal step %0d: state=%0d track=%b road=%0d gd=%b fault=%b, required state=%0d track=%b",
                         i, state_o, track, road, gate_down, fault, q[i][6:4], q[i][3:0]);
            end
        end
    endtask

    task automatic test_second_track();
        logic [10:0] q[$];
        q = '{ {2'b01,1'b0,1'b0,S_RY,T_RR}, {2'b01,1'b0,1'b0,S_RY,T_RR},
               {2'b01,1'b0,1'b0,S_GL,T_RR}, {2'b01,1'b1,1'b0,S_TG,T_G0},
               {2'b11,1'b1,1'b0,S_TG,T_GG}, {2'b10,1'b1,1'b0,S_TG,T_G1},
               {2'b00,1'b1,1'b0,S_TY,T_YY}, {2'b00,1'b1,1'b0,S_TY,T_YY},
               {2'b00,1'b1,1'b0,S_GR,T_RR}, {2'b00,1'b0,1'b0,S_RG,T_RR} };
        foreach (q[i]) begin
            {train, gate_closed, fault_clr} = q[i][10:7];
            if (i == 4) begin
                #1;
                checks++;
                if (track !== T_GG) begin
                    errors++; $display("FAIL join_same_cycle: track=%b, required %b", track, T_GG);
                end
            end
            @(posedge clk); #1;
            checks++;
            if (state_o !== q[i][6:4] || track !== q[i][3:0] || road !== ROAD_EXP[q[i][6:4]] ||
                gate_down !== GD_EXP[q[i][6:4]] || fault !== (q[i][6:4] == S_F)) begin
                errors++;
                $display("FAIL join step %0d: state=%0d track=%b road=%0d gd=%b fault=%b, required state=%0d track=%b",
                         i, state_o, track, road, gate_down, fault, q[i][6:4], q[i][3:0]);
            end
        end
    endtask

    task automatic test_rearrival();
        logic [10:0] q[$];
        q = '{ {2'b01,1'b0,1'b0,S_RY,T_RR}, {2'b01,1'b0,1'b0,S_RY,T_RR},
               {2'b01,1'b0,1'b0,S_GL,T_RR}, {2'b01,1'b1,1'b0,S_TG,T_G0},
               {2'b00,1'b1,1'b0,S_TY,T_YY}, {2'b01,1'b1,1'b0,S_TG,T_G0},
               {2'b00,1'b1,1'b0,S_TY,T_YY}, {2'b00,1'b1,1'b0,S_TY,T_YY},
               {2'b00,1'b1,1'b0,S_GR,T_RR}, {2'b10,1'b1,1'b0,S_GL,T_RR},
               {2'b10,1'b1,1'b0,S_TG,T_G1}, {2'b00,1'b1,1'b0,S_TY,T_YY},
               {2'b00,1'b1,1'b0,S_TY,T_YY}, {2'b00,1'b1,1'b0,S_GR,T_RR},
               {2'b00,1'b0,1'b0,S_RG,T_RR} };
        foreach (q[i]) begin
            {train, gate_closed, fault_clr} = q[i][10:7];
            @(posedge clk); #1;
            checks++;
            if (state_o !== q[i][6:4] || track !== q[i][3:0] || road !== ROAD_EXP[q[i][6:4]] ||
                gate_down !== GD_EXP[q[i][6:4]] || fault !== (q[i][6:4] == S_F)) begin
                errors++;
                $display("FAIL rearrival step %0d: state=%0d track=%b road=%0d gd=%b fault=%b, required state=%0d track=%b",
                         i, state_o, track, road, gate_down, fault, q[i][6:4], q[i][3:0]);
            end
        end
    endtask

    task automatic test_timeouts();
        logic [10:0] q[$];
        // Lowering timeout, sticky fault, ignored and accepted fault_clr.
        q.push_back({2'b01,1'b0,1'b0,S_RY,T_RR});
        q.push_back({2'b01,1'b0,1'b0,S_RY,T_RR});
        for (int k = 0; k < 16; k++) q.push_back({2'b01,1'b0,1'b0,S_GL,T_RR});
        q.push_back({2'b01,1'b0,1'b0,S_F,T_RR});
        q.push_back({2'b01,1'b0,1'b1,S_F,T_RR});
        q.push_back({2'b01,1'b0,1'b1,S_F,T_RR});
        q.push_back({2'b00,1'b0,1'b0,S_F,T_RR});
        q.push_back({2'b00,1'b0,1'b1,S_GR,T_RR});
        q.push_back({2'b00,1'b0,1'b0,S_RG,T_RR});
        // gate_closed arriving on the last lowering cycle beats the timeout.
        q.push_back({2'b01,1'b0,1'b0,S_RY,T_RR});
        q.push_back({2'b01,1'b0,1'b0,S_RY,T_RR});
        for (int k = 0; k < 16; k++) q.push_back({2'b01,1'b0,1'b0,S_GL,T_RR});
        q.push_back({2'b01,1'b1,1'b0,S_TG,T_G0});
        // Raising timeout with the sensor stuck closed.
        q.push_back({2'b00,1'b1,1'b0,S_TY,T_YY});
        q.push_back({2'b00,1'b1,1'b0,S_TY,T_YY});
        for (int k = 0; k < 16; k++) q.push_back({2'b00,1'b1,1'b0,S_GR,T_RR});
        q.push_back({2'b00,1'b1,1'b0,S_F,T_RR});
        q.push_back({2'b00,1'b1,1'b1,S_GR,T_RR});
        q.push_back({2'b00,1'b0,1'b0,S_RG,T_RR});
        foreach (q[i]) begin
            {train, gate_closed, fault_clr} = q[i][10:7];
            @(posedge clk); #1;
            checks++;
            if (state_o !== q[i][6:4] || track !== q[i][3:0] || road !== ROAD_EXP[q[i][6:4]] ||
                gate_down !== GD_EXP[q[i][6:4]] || fault !== (q[i][6:4] == S_F)) begin
                errors++;
                $display("FAIL timeout step %0d: state=%0d track=%b road=%0d gd=%b fault=%b, required state=%0d track=%b",
                         i, state_o, track, road, gate_down, fault, q[i][6:4], q[i][3:0]);
            end
        end
        fault_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [10:0] q[$];
        q = '{ {2'b01,1'b0,1'b0,S_RY,T_RR}, {2'b01,1'b0,1'b0,S_RY,T_RR},
               {2'b01,1'b0,1'b0,S_GL,T_RR}, {2'b01,1'b1,1'b0,S_TG,T_G0} };
        foreach (q[i]) begin
            {train, gate_closed, fault_clr} = q[i][10:7];
            @(posedge clk); #1;
            checks++;
            if (state_o !== q[i][6:4] || track !== q[i][3:0] || road !== ROAD_EXP[q[i][6:4]] ||
                gate_down !== GD_EXP[q[i][6:4]] || fault !== (q[i][6:4] == S_F)) begin
                errors++;
                $display("FAIL async_pre step %0d: state=%0d track=%b road=%0d gd=%b fault=%b, required state=%0d track=%b",
                         i, state_o, track, road, gate_down, fault, q[i][6:4], q[i][3:0]);
            end
        end
        #1 clr_n = 1'b0;
        train = 2'b00;
        gate_closed = 1'b0;
        #1;
        checks++;
        if (state_o !== S_RG || road !== 2'd2 || track !== T_RR || gate_down !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: state=%0d road=%0d track=%b gd=%b fault=%b, required 0 2 0000 0 0",
                     state_o, road, track, gate_down, fault);
        end
        #1 clr_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (state_o !== S_RG) begin
            errors++; $display("FAIL async_release: state=%0d, required 0", state_o);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_second_track();
        test_rearrival();
        test_timeouts();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before 200000");
        $fatal(1);
    end

endmodule
